// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the memory-stage initiator and the data-memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rvalid;
    logic        addr_err;

    modport master (
        output req_valid, req_write, req_be, req_addr, req_wdata,
        input  stall, rdata, rvalid, addr_err
    );

    modport slave (
        input  req_valid, req_write, req_be, req_addr, req_wdata,
        output stall, rdata, rvalid, addr_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, stalls the pipeline
// for LATENCY cycles and returns load data in the cycle stall drops.
module data_mem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256,
    parameter int AW      = 8
) (
    input  logic              clock,
    input  logic              reset,
    data_mem_responder_if.slave bus
);

    localparam int CW = 4;
    localparam logic [CW-1:0] COUNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            stall_comb;

    logic            write_reg;
    logic [3:0]      be_reg;
    logic [AW-1:0]   index_reg;
    logic [31:0]     wdata_reg;
    logic            in_range_reg;
    logic            rvalid_reg;
    logic            addr_err_reg;
    logic [31:0]     rdata_bus;

    logic            accept;
    logic            enter_done;
    logic [AW-1:0]   req_index;
    logic            req_in_range;
    logic            req_misaligned;

    // Operation seen at the DONE-entry edge: live request when LATENCY=1, latched copy otherwise
    logic            acc_write;
    logic [3:0]      acc_be;
    logic [AW-1:0]   acc_index;
    logic [31:0]     acc_wdata;
    logic            acc_in_range;

    assign req_index      = bus.req_addr[AW+1:2];
    assign req_in_range   = (bus.req_addr[31:AW+2] == '0);
    assign req_misaligned = (bus.req_addr[1:0] != 2'b00);

    assign accept     = (state_reg == IDLE) && bus.req_valid;
    assign enter_done = (state_next == DONE) && reset;

    assign acc_write    = accept ? bus.req_write : write_reg;
    assign acc_be       = accept ? bus.req_be    : be_reg;
    assign acc_index    = accept ? req_index     : index_reg;
    assign acc_wdata    = accept ? bus.req_wdata : wdata_reg;
    assign acc_in_range = accept ? req_in_range  : in_range_reg;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        stall_comb = 1'b0;
        case (state_reg)
            IDLE: begin
                stall_comb = bus.req_valid && reset;
                if (bus.req_valid) begin
                    count_next = COUNT_INIT;
                    state_next = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall_comb = 1'b1;
                if (count_reg == '0) begin
                    state_next = DONE;
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            write_reg    <= 1'b0;
            be_reg       <= '0;
            index_reg    <= '0;
            wdata_reg    <= '0;
            in_range_reg <= 1'b0;
            rvalid_reg   <= 1'b0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            rvalid_reg <= enter_done && !acc_write;
            if (accept) begin
                write_reg    <= bus.req_write;
                be_reg       <= bus.req_be;
                index_reg    <= req_index;
                wdata_reg    <= bus.req_wdata;
                in_range_reg <= req_in_range;
                if (req_misaligned || !req_in_range) begin
                    addr_err_reg <= 1'b1;
                end
            end
        end
    end

    // One RAM per byte lane so byte enables map onto independent write ports
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [DEPTH];
            logic [7:0] rdata_lane_reg;

            always_ff @(posedge clock) begin
                if (enter_done && acc_write && acc_in_range && acc_be[gi]) begin
                    ram[acc_index] <= acc_wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    rdata_lane_reg <= '0;
                end else if (enter_done && !acc_write) begin
                    rdata_lane_reg <= acc_in_range ? ram[acc_index] : 8'h00;
                end
            end

            assign rdata_bus[8*gi +: 8] = rdata_lane_reg;
        end
    endgenerate

    assign bus.stall    = stall_comb;
    assign bus.rdata    = rdata_bus;
    assign bus.rvalid   = rvalid_reg;
    assign bus.addr_err = addr_err_reg;

endmodule
